serial_adder: RTL

- Bit-serial N-bit adder: the addition counterpart of the team's ripple subtractor cells.
- Captures two operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, through a single full-adder cell and a registered carry.
- Reports sum, carry-out and signed overflow with a one-cycle done strobe.
- Used wherever area matters more than latency, such as clock/time-of-day arithmetic on the Spartan-3 board.

---
 rtl/serial_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a registered carry, LSB first.
// A start accepted at edge k gives done in the cycle after edge k+WIDTH; start is ignored while busy.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the WIDTH-1 low sum bits; the MSB is merged in directly on the last RUN cycle.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             s_bit, c_nxt;

  assign s_bit = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign c_nxt = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        acc_d  = (WIDTH-1)'({s_bit, acc_q} >> 1);
        c_d    = c_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // c_q here is the carry into the MSB, so overflow needs no separate register.
          state_d = DONE;
          sum_d   = {s_bit, acc_q};
          cout_d  = c_nxt;
          ovf_d   = c_q ^ c_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
